// File: rtl/fp_addsub_arbiter.sv
// Round-robin scheduler sharing one pipelined FP add/sub unit between NUM_REQ requesters.
// A valid/tag shift pipeline routes each registered result back to its issuer as a done pulse.
module fp_addsub_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 4,
    parameter int TAG_W   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   hold_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ-1:0]     req_op_i,
    input  logic [32*NUM_REQ-1:0]  req_a_i,
    input  logic [32*NUM_REQ-1:0]  req_b_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [NUM_REQ-1:0]     done_o,
    output logic [31:0]            result_out_o,
    output logic                   busy_o,
    output logic [31:0]            fpu_a_o,
    output logic [31:0]            fpu_b_o,
    output logic                   fpu_op_o,
    output logic                   fpu_ce_o,
    input  logic [31:0]            fpu_result_i
);

    localparam logic [TAG_W-1:0]   PTR_RST = TAG_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);

    // Adder expects canonical zero; -0.0 is mapped to +0.0 before issue.
    function automatic logic [31:0] scrub(input logic [31:0] x);
        return (x[30:0] == 31'd0) ? 32'd0 : x;
    endfunction

    logic [TAG_W-1:0]              ptr_q, ptr_d;
    logic [TAG_W-1:0]              gnt_idx;
    logic                          gnt_found;
    logic                          issue;
    logic [31:0]                   a_sel, b_sel;
    logic                          op_sel;
    logic [31:0]                   fpu_a_q, fpu_a_d;
    logic [31:0]                   fpu_b_q, fpu_b_d;
    logic                          fpu_op_q, fpu_op_d;
    logic [31:0]                   result_q, result_d;
    logic [LATENCY:0]              vld_q, vld_d;
    logic [LATENCY:0][TAG_W-1:0]   tag_q, tag_d;
    int                            j;

    // Rotating priority search starting just above the last winner.
    always_comb begin
        gnt_idx   = '0;
        gnt_found = 1'b0;
        j         = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!gnt_found && req_i[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = TAG_W'(j);
            end
        end
    end

    assign issue   = gnt_found & ~hold_i;
    assign grant_o = issue ? (ONE << gnt_idx) : '0;

    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        op_sel = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == TAG_W'(i)) begin
                a_sel  = req_a_i[32*i +: 32];
                b_sel  = req_b_i[32*i +: 32];
                op_sel = req_op_i[i];
            end
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        fpu_a_d  = fpu_a_q;
        fpu_b_d  = fpu_b_q;
        fpu_op_d = fpu_op_q;
        result_d = result_q;
        vld_d    = vld_q;
        tag_d    = tag_q;
        if (issue) begin
            ptr_d    = gnt_idx;
            fpu_a_d  = scrub(a_sel);
            fpu_b_d  = scrub(b_sel);
            fpu_op_d = op_sel;
        end
        // The adder, pipeline and capture register all advance on the same enabled edges,
        // so stage k always lines up with the adder's internal stage k.
        if (!hold_i) begin
            vld_d    = {vld_q[LATENCY-1:0], issue};
            tag_d    = {tag_q[LATENCY-1:0], gnt_idx};
            result_d = fpu_result_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q    <= PTR_RST;
            fpu_a_q  <= '0;
            fpu_b_q  <= '0;
            fpu_op_q <= 1'b0;
            result_q <= '0;
            vld_q    <= '0;
            tag_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            fpu_a_q  <= fpu_a_d;
            fpu_b_q  <= fpu_b_d;
            fpu_op_q <= fpu_op_d;
            result_q <= result_d;
            vld_q    <= vld_d;
            tag_q    <= tag_d;
        end
    end

    assign done_o       = (vld_q[LATENCY] && !hold_i) ? (ONE << tag_q[LATENCY]) : '0;
    assign result_out_o = result_q;
    assign busy_o       = |vld_q;
    assign fpu_a_o      = fpu_a_q;
    assign fpu_b_o      = fpu_b_q;
    assign fpu_op_o     = fpu_op_q;
    assign fpu_ce_o     = ~hold_i;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Directed bench: drives fp_addsub_arbiter with a table-lookup model of the shared adder.
module tb_fp_addsub_arbiter;
    localparam int N = 4;
    localparam int L = 4;

    logic          clk = 1'b0;
    logic          rst, hold;
    logic [N-1:0]  req, req_op;
    logic [32*N-1:0] req_a, req_b;
    logic [N-1:0]  grant, done;
    logic [31:0]   result_out, fpu_a, fpu_b, fpu_result;
    logic          busy, fpu_op, fpu_ce;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    fp_addsub_arbiter #(.NUM_REQ(N), .LATENCY(L), .TAG_W(2)) dut (
        .clk_i(clk), .rst_i(rst), .hold_i(hold), .req_i(req), .req_op_i(req_op),
        .req_a_i(req_a), .req_b_i(req_b), .grant_o(grant), .done_o(done),
        .result_out_o(result_out), .busy_o(busy), .fpu_a_o(fpu_a), .fpu_b_o(fpu_b),
        .fpu_op_o(fpu_op), .fpu_ce_o(fpu_ce), .fpu_result_i(fpu_result)
    );

    // Shared adder model: result valid LATENCY cycles after the grant cycle.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic op);
        case ({op, a, b})
            {1'b0, 32'h3F800000, 32'h40000000}: return 32'h40400000;
            {1'b0, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {1'b1, 32'h40400000, 32'h3F800000}: return 32'h40000000;
            {1'b1, 32'h40000000, 32'h3F800000}: return 32'h3F800000;
            {1'b0, 32'h40000000, 32'h40000000}: return 32'h40800000;
            {1'b0, 32'h00000000, 32'h00000000}: return 32'h00000000;
            default:                            return 32'hDEADBEEF;
        endcase
    endfunction

    logic [31:0] fp_pipe [L-1] = '{default: 32'h0};
    always @(posedge clk) begin
        if (fpu_ce) begin
            fp_pipe[0] <= fadd(fpu_a, fpu_b, fpu_op);
            for (int i = 1; i < L-1; i++) fp_pipe[i] <= fp_pipe[i-1];
        end
    end
    assign fpu_result = fp_pipe[L-2];

    task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got %h want %h", t, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[i] = op;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; hold = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    logic [31:0] rr_res [N] = '{32'h40400000, 32'h40000000, 32'h3F800000, 32'h40800000};

    initial begin
        rst = 1'b1; hold = 1'b0; req = '0; req_op = '0; req_a = '0; req_b = '0;
        tick(); tick();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_result", result_out, 0);
        chk("rst_fpu_a", fpu_a, 0);
        chk("rst_fpu_op", 32'(fpu_op), 0);
        rst = 1'b0;

        // Single add 1.0 + 2.0
        set_op(0, 32'h3F800000, 32'h40000000, 1'b0);
        req = 4'b0001;
        #1 chk("single_grant", 32'(grant), 32'b0001);
        for (int c = 1; c <= 6; c++) begin
            tick();
            req = '0;
            if (c == 1) chk("single_fpu_a", fpu_a, 32'h3F800000);
            chk($sformatf("single_busy_c%0d", c), 32'(busy), (c <= 5) ? 1 : 0);
            chk($sformatf("single_done_c%0d", c), 32'(done), (c == 5) ? 1 : 0);
            if (c == 5) chk("single_result", result_out, 32'h40400000);
        end

        // Round robin, all four requesting for 8 cycles
        do_reset();
        set_op(0, 32'h3F800000, 32'h40000000, 1'b0);
        set_op(1, 32'h3F800000, 32'h3F800000, 1'b0);
        set_op(2, 32'h40000000, 32'h3F800000, 1'b1);
        set_op(3, 32'h40000000, 32'h40000000, 1'b0);
        for (int c = 0; c < 14; c++) begin
            if (c > 0) tick();
            req = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            chk($sformatf("rr_grant_c%0d", c), 32'(grant), (c < 8) ? (1 << (c % 4)) : 0);
            chk($sformatf("rr_done_c%0d", c), 32'(done), (c >= 5 && c < 13) ? (1 << ((c - 5) % 4)) : 0);
            if (c >= 5 && c < 13) chk($sformatf("rr_result_c%0d", c), result_out, rr_res[(c - 5) % 4]);
        end

        // Negative zero scrubbing
        do_reset();
        set_op(0, 32'h80000000, 32'h80000000, 1'b0);
        req = 4'b0001;
        for (int c = 1; c <= 5; c++) begin
            tick();
            req = '0;
            if (c == 1) begin
                chk("negz_fpu_a", fpu_a, 0);
                chk("negz_fpu_b", fpu_b, 0);
            end
        end
        chk("negz_done", 32'(done), 1);
        chk("negz_result", result_out, 0);

        // Subtract with tag routing
        do_reset();
        set_op(1, 32'h3F800000, 32'h3F800000, 1'b0);
        set_op(2, 32'h40400000, 32'h3F800000, 1'b1);
        req = 4'b0110;
        #1 chk("sub_grant_c0", 32'(grant), 32'b0010);
        tick();
        req = 4'b0100;
        #1 chk("sub_grant_c1", 32'(grant), 32'b0100);
        for (int c = 2; c <= 7; c++) begin
            tick();
            req = '0;
            chk($sformatf("sub_done_c%0d", c), 32'(done), (c == 5) ? 32'b0010 : (c == 6) ? 32'b0100 : 0);
            if (c == 5 || c == 6) chk($sformatf("sub_result_c%0d", c), result_out, 32'h40000000);
        end

        // Hold for 3 cycles mid-flight
        do_reset();
        set_op(0, 32'h3F800000, 32'h40000000, 1'b0);
        set_op(1, 32'h3F800000, 32'h3F800000, 1'b0);
        req = 4'b0001;
        tick();
        req = 4'b0010;
        #1 chk("hold_grant_c1", 32'(grant), 32'b0010);
        for (int c = 2; c <= 11; c++) begin
            tick();
            hold = (c >= 3 && c <= 5);
            req  = hold ? 4'b1111 : 4'b0000;
            #1;
            chk($sformatf("hold_grant_c%0d", c), 32'(grant), 0);
            chk($sformatf("hold_ce_c%0d", c), 32'(fpu_ce), hold ? 0 : 1);
            chk($sformatf("hold_done_c%0d", c), 32'(done), (c == 8) ? 32'b0001 : (c == 9) ? 32'b0010 : 0);
            if (c == 8) chk("hold_result_c8", result_out, 32'h40400000);
            if (c == 9) chk("hold_result_c9", result_out, 32'h40000000);
        end
        hold = 1'b0;

        // Reset mid-flight
        do_reset();
        set_op(0, 32'h3F800000, 32'h40000000, 1'b0);
        set_op(1, 32'h3F800000, 32'h3F800000, 1'b0);
        set_op(2, 32'h40000000, 32'h3F800000, 1'b1);
        req = 4'b0111;
        for (int c = 1; c <= 12; c++) begin
            tick();
            req = (c < 3) ? 4'b0111 : 4'b0000;
            rst = (c == 4);
            #1;
            if (c == 4) chk("mrst_busy_c4", 32'(busy), 1);
            if (c == 5) chk("mrst_busy_c5", 32'(busy), 0);
            chk($sformatf("mrst_done_c%0d", c), 32'(done), 0);
        end
        req = 4'b1010;
        set_op(1, 32'h3F800000, 32'h3F800000, 1'b0);
        set_op(3, 32'h40000000, 32'h40000000, 1'b0);
        #1 chk("mrst_first_grant", 32'(grant), 32'b0010);
        tick();
        req = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
